// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the MIPS execute stage; owns HI/LO.
// One multiplier/quotient bit per cycle, N cycles per operation.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_s,
  input  logic [N-1:0] i_t,
  input  logic         i_hi_we,
  input  logic         i_lo_we,
  input  logic [N-1:0] i_wdata,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_div_zero,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t r_state, w_state_next;

  logic [CW-1:0]  r_count;
  logic           r_is_div, r_neg_q, r_neg_r, r_div_zero;
  logic [N-1:0]   r_a, r_b, r_hi, r_lo;
  logic [2*N-1:0] r_acc;
  logic           r_done, r_dz_pulse;

  logic           w_accept, w_last, w_signed;
  logic [N-1:0]   w_s_mag, w_t_mag, w_quot, w_rem, w_dz_hi;
  logic [N:0]     w_sum, w_shift, w_diff;
  logic [2*N-1:0] w_acc_next, w_prod;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: if (i_start) begin
        w_state_next = RUN;
        w_accept     = 1'b1;
      end
      RUN: begin
        o_busy = 1'b1;
        if (r_count == LAST) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operands are reduced to magnitudes; signs are reapplied on completion.
  assign w_signed = ~i_op[0];
  assign w_s_mag  = (w_signed && i_s[N-1]) ? -i_s : i_s;
  assign w_t_mag  = (w_signed && i_t[N-1]) ? -i_t : i_t;

  // Multiply keeps the multiplier in the low half of the accumulator;
  // divide keeps the remainder high and shifts quotient bits into the low half.
  assign w_sum   = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_shift = {r_acc[2*N-1:N], r_acc[N-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  always_comb begin
    w_acc_next = {w_sum, r_acc[N-1:1]};
    if (r_is_div) begin
      if (w_diff[N]) w_acc_next = {w_shift[N-1:0], r_acc[N-2:0], 1'b0};
      else           w_acc_next = {w_diff[N-1:0],  r_acc[N-2:0], 1'b1};
    end
  end

  assign w_prod  = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quot  = r_neg_q ? -w_acc_next[N-1:0] : w_acc_next[N-1:0];
  assign w_rem   = r_neg_r ? -w_acc_next[2*N-1:N] : w_acc_next[2*N-1:N];
  assign w_dz_hi = r_neg_r ? -r_a : r_a;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      if (w_accept) begin
        r_is_div   <= i_op[1];
        r_neg_q    <= w_signed & (i_s[N-1] ^ i_t[N-1]);
        r_neg_r    <= w_signed & i_s[N-1];
        r_div_zero <= i_op[1] && (i_t == '0);
        r_a        <= w_s_mag;
        r_b        <= w_t_mag;
        r_acc      <= {{N{1'b0}}, (i_op[1] ? w_s_mag : w_t_mag)};
        r_count    <= '0;
      end else if (o_busy) begin
        r_acc   <= w_acc_next;
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_done <= 1'b1;
          if (!r_is_div) begin
            r_hi <= w_prod[2*N-1:N];
            r_lo <= w_prod[N-1:0];
          end else if (r_div_zero) begin
            r_hi       <= w_dz_hi;
            r_lo       <= '1;
            r_dz_pulse <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
        end
      end else begin
        if (i_hi_we) r_hi <= i_wdata;
        if (i_lo_we) r_lo <= i_wdata;
      end
    end
  end

  assign o_done     = r_done;
  assign o_div_zero = r_dz_pulse;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        i_clk, i_reset, i_start, i_hi_we, i_lo_we;
  logic [1:0]  i_op;
  logic [31:0] i_s, i_t, i_wdata;
  logic        o_busy, o_done, o_div_zero;
  logic [31:0] o_hi, o_lo;

  int nTotal = 0;
  int nBad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] s, t, hi, lo;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  muldiv_unit #(.N(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_s(i_s), .i_t(i_t), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_div_zero(o_div_zero), .o_hi(o_hi), .o_lo(o_lo)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTotal++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: plain wide arithmetic, truncating signed division.
  function automatic void model(input logic [1:0] op, input logic [31:0] s, input logic [31:0] t,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    sa = $signed(s);
    sb = $signed(t);
    hi = '0;
    lo = '0;
    if (op == 2'b00 || op == 2'b01) begin
      if (op == 2'b00) p = sa * sb;
      else             p = {32'b0, s} * {32'b0, t};
      hi = p[63:32];
      lo = p[31:0];
    end else if (t == 32'd0) begin
      hi = s;
      lo = 32'hFFFFFFFF;
      dz = 1'b1;
    end else if (op == 2'b11) begin
      lo = s / t;
      hi = s % t;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  // Issue one op (called at posedge+1) and return after the done pulse is seen.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] s, input logic [31:0] t, output int lat);
    logic [31:0] hiPrev, loPrev;
    bit unstable, overlap;
    hiPrev = o_hi;
    loPrev = o_lo;
    unstable = 0;
    overlap = 0;
    i_op = op; i_s = s; i_t = t; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
    checkOutput("accept_busy", {31'b0, o_busy}, 32'd1);
    checkOutput("accept_done_low", {31'b0, o_done}, 32'd0);
    lat = 0;
    while (!o_done && lat < 200) begin
      if (o_hi !== hiPrev || o_lo !== loPrev) unstable = 1;
      @(posedge i_clk); #1;
      lat++;
      if (o_done && o_busy) overlap = 1;
    end
    checkOutput("latency", lat, 32'd32);
    checkOutput("hilo_stable_run", {31'b0, unstable}, 32'd0);
    checkOutput("done_with_busy", {31'b0, overlap}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, doneCount, edges;
    logic [31:0] eHi, eLo, doneHi, doneLo;
    logic eDz;

    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{2'b11, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0};
    vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[7] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9] = '{2'b01, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0};

    // Reset, with start and HI/LO writes held high to show reset wins.
    i_reset = 1'b1; i_start = 1'b1; i_op = 2'b01; i_s = 32'd9; i_t = 32'd9;
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hFFFF;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("reset_done", {31'b0, o_done}, 32'd0);
    checkOutput("reset_dz", {31'b0, o_div_zero}, 32'd0);
    checkOutput("reset_hi", o_hi, 32'd0);
    checkOutput("reset_lo", o_lo, 32'd0);
    i_reset = 1'b0; i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;

    // Directed table, issued back-to-back in each done cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].s, vecs[i].t, lat);
      checkOutput($sformatf("vec%0d_hi", i), o_hi, vecs[i].hi);
      checkOutput($sformatf("vec%0d_lo", i), o_lo, vecs[i].lo);
      checkOutput($sformatf("vec%0d_dz", i), {31'b0, o_div_zero}, {31'b0, vecs[i].dz});
      checkOutput($sformatf("vec%0d_busy", i), {31'b0, o_busy}, 32'd0);
    end

    // start and MTHI while busy are ignored.
    i_op = 2'b11; i_s = 32'd1000; i_t = 32'd7; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    edges = 0;
    repeat (5) begin @(posedge i_clk); #1; edges++; end
    i_start = 1'b1; i_op = 2'b01; i_s = 32'd2; i_t = 32'd3; i_hi_we = 1'b1; i_wdata = 32'h55;
    @(posedge i_clk); #1; edges++;
    i_start = 1'b0; i_hi_we = 1'b0;
    doneCount = 0; lat = 0; doneHi = '0; doneLo = '0;
    repeat (80) begin
      if (o_done) begin
        if (doneCount == 0) lat = edges;
        doneCount++;
        doneHi = o_hi;
        doneLo = o_lo;
      end
      @(posedge i_clk); #1; edges++;
    end
    checkOutput("ignore_done_count", doneCount, 32'd1);
    checkOutput("ignore_latency", lat, 32'd32);
    checkOutput("ignore_hi", doneHi, 32'd6);
    checkOutput("ignore_lo", doneLo, 32'd142);

    // Direct HI/LO writes while idle.
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h1234;
    @(posedge i_clk); #1;
    i_hi_we = 1'b0; i_lo_we = 1'b0;
    checkOutput("mt_both_hi", o_hi, 32'h1234);
    checkOutput("mt_both_lo", o_lo, 32'h1234);
    i_hi_we = 1'b1; i_wdata = 32'hABCD;
    @(posedge i_clk); #1;
    i_hi_we = 1'b0;
    checkOutput("mthi_hi", o_hi, 32'hABCD);
    checkOutput("mthi_lo", o_lo, 32'h1234);
    i_lo_we = 1'b1; i_wdata = 32'h5A5A;
    @(posedge i_clk); #1;
    i_lo_we = 1'b0;
    checkOutput("mtlo_hi", o_hi, 32'hABCD);
    checkOutput("mtlo_lo", o_lo, 32'h5A5A);
    // start in the same cycle drops the writes.
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h9999;
    applyStimulus(2'b01, 32'd2, 32'd3, lat);
    checkOutput("mt_drop_hi", o_hi, 32'd0);
    checkOutput("mt_drop_lo", o_lo, 32'd6);

    // Reset mid-operation discards the op.
    @(posedge i_clk); #1;
    i_op = 2'b00; i_s = 32'd5; i_t = 32'd5; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (9) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    checkOutput("midrst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("midrst_done", {31'b0, o_done}, 32'd0);
    checkOutput("midrst_hi", o_hi, 32'd0);
    checkOutput("midrst_lo", o_lo, 32'd6 & 32'd0);
    doneCount = 0;
    repeat (40) begin
      if (o_done || o_busy) doneCount++;
      @(posedge i_clk); #1;
    end
    checkOutput("midrst_no_done", doneCount, 32'd0);
    applyStimulus(2'b01, 32'd5, 32'd5, lat);
    checkOutput("after_rst_hi", o_hi, 32'd0);
    checkOutput("after_rst_lo", o_lo, 32'd25);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [31:0] rs, rt;
      rop = 2'($urandom_range(0, 3));
      rs = pick();
      rt = pick();
      model(rop, rs, rt, eHi, eLo, eDz);
      applyStimulus(rop, rs, rt, lat);
      checkOutput($sformatf("rnd%0d_op%0d_hi", i, rop), o_hi, eHi);
      checkOutput($sformatf("rnd%0d_op%0d_lo", i, rop), o_lo, eLo);
      checkOutput($sformatf("rnd%0d_dz", i), {31'b0, o_div_zero}, {31'b0, eDz});
      if ($urandom_range(0, 1) == 1) begin @(posedge i_clk); #1; end
    end

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS execute stage. It services MULT, MULTU, DIV and DIVU, which the combinational ALU does not implement, and owns the architectural HI/LO registers.
- The pipeline issues an operation with a start strobe, stalls on busy, and reads HI/LO once done pulses.
- Direct HI/LO writes (MTHI/MTLO) are accepted when the unit is idle.

Parameters:
- N, 32, operand and HI/LO width. Iteration count equals N.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when busy=0.
- op  in  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- s  in  N  first operand (multiplicand / dividend).
- t  in  N  second operand (multiplier / divisor).
- hi_we  in  1  write wdata into HI (MTHI).
- lo_we  in  1  write wdata into LO (MTLO).
- wdata  in  N  data for hi_we/lo_we.
- busy  out  1  operation in progress; the pipeline must stall on MFHI/MFLO/new op.
- done  out  1  one-cycle pulse: HI/LO hold the new result.
- div_zero  out  1  one-cycle pulse with done when a DIV/DIVU had t==0.
- hi  out  N  HI register.
- lo  out  N  LO register.

Behaviour:
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0, FSM=IDLE, iteration counter=0.
- Reset wins over every other input on the same edge, including mid-operation. An in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, plus the done pulse on the exit edge.
  - IDLE -> RUN on an edge with start=1.
  - RUN -> IDLE on iteration edge N.
- Accept edge E0: latch op, the operand magnitudes (|s|, |t| for signed ops; raw for unsigned) and the result sign. busy becomes 1 and the counter clears.
- Iterations on edges E1..EN:
  - Multiply: shift-add, one multiplier bit per edge, 2N-bit accumulator.
  - Divide: restoring, one quotient bit per edge.
- Edge EN (completion):
  - Multiply: {hi,lo} = 2N-bit product, negated if the signs differ (signed only).
  - Divide: lo = quotient, hi = remainder. The quotient is negated if the operand signs differ; the remainder takes the sign of s (truncating division).
  - Also on EN: busy->0 and done->1.
- done (and div_zero, when applicable) deasserts on edge EN+1. Latency from the accept edge to HI/LO valid is exactly N edges (N+1 edges from start being sampled).
- Divide by zero (t==0, DIV or DIVU): same latency. Result hi=s (unmodified operand), lo={N{1'b1}}, div_zero=1 with done.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap), div_zero=0.
- start while busy=1 is ignored: no queueing, operands not relatched.
- hi_we/lo_we:
  - Applied on the edge only when busy=0 and start=0. hi_we and lo_we may both be 1 in the same cycle.
  - Ignored while busy.
  - If start=1 in the same cycle, start wins and the writes are dropped.
- hi and lo are stable during RUN; they hold the previous values until edge EN.
- done is never asserted together with busy.
- A new start may be accepted on the same edge that done deasserts (back-to-back: start high in the done cycle).

Test Plan:
- Reset, then MULTU s=0xFFFFFFFF t=0xFFFFFFFF -> busy for 32 cycles, done pulse one cycle, hi=0xFFFFFFFE lo=0x00000001.
- MULT s=0xFFFFFFFD (-3) t=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then DIV s=0xFFFFFFF9 (-7) t=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU s=100 t=0 -> done with div_zero=1, hi=0x00000064, lo=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- During a running DIVU 1000/7: pulse start with MULTU 2*3 and assert hi_we=1 wdata=0x55 -> both ignored. Final hi=6, lo=142, exactly one done pulse.
- Idle: hi_we=1 lo_we=1 wdata=0x1234 -> hi=lo=0x1234 next edge. Repeat with start=1 in the same cycle (MULTU 2*3) -> write dropped, result hi=0 lo=6.
- Start MULT 5*5, assert reset at iteration 10 -> busy=0, hi=lo=0 next edge, no done. A following MULTU 5*5 completes normally with lo=25, hi=0.
